// File: rtl/disp_num_fmt.sv
// Seven-segment number formatter: converts a 32-bit value to eight hex or
// BCD digit codes (double-dabble), with optional leading-zero blanking.
module disp_num_fmt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        mode,
  input  logic        lz_en,
  output logic        busy,
  output logic        done,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        lz_q, lz_d;
  logic        done_q, done_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  blank_q, blank_d;
  logic        ovf_q, ovf_d;

  logic [39:0] bcd_adj;
  logic [31:0] fmt_digits;
  logic [7:0]  fmt_blank;
  logic        zero_run;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Blank a display only when it and every display above it shows zero.
  always_comb begin
    fmt_digits = mode_q ? bcd_q[31:0] : bin_q;
    fmt_blank  = 8'h00;
    zero_run   = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      zero_run     = zero_run & (fmt_digits[4*k +: 4] == 4'd0);
      fmt_blank[k] = lz_q & zero_run;
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    lz_d     = lz_q;
    done_d   = 1'b0;
    digits_d = digits_q;
    blank_d  = blank_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = value;
          mode_d  = mode;
          lz_d    = lz_en;
          bcd_d   = 40'h0;
          cnt_d   = 6'd0;
          state_d = mode ? SHIFT : FINISH;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[38:0], bin_q[31]};
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        digits_d = fmt_digits;
        blank_d  = fmt_blank;
        ovf_d    = mode_q & (|bcd_q[39:32]);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bin_q    <= 32'h0;
      bcd_q    <= 40'h0;
      cnt_q    <= 6'd0;
      mode_q   <= 1'b0;
      lz_q     <= 1'b0;
      done_q   <= 1'b0;
      digits_q <= 32'h0;
      blank_q  <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      lz_q     <= lz_d;
      done_q   <= done_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign digits   = digits_q;
  assign blank    = blank_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_disp_num_fmt.sv
// Self-checking bench for disp_num_fmt: directed cases plus random requests
// compared against an arithmetic reference model.
module tb_disp_num_fmt;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] value;
  logic        mode;
  logic        lz_en;
  logic        busy;
  logic        done;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic        overflow;

  int          n_vec;
  int          n_err;
  logic [31:0] last_digits;
  logic [7:0]  last_blank;
  logic        last_ovf;

  disp_num_fmt dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value    (value),
    .mode     (mode),
    .lz_en    (lz_en),
    .busy     (busy),
    .done     (done),
    .digits   (digits),
    .blank    (blank),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division, blanking by counting
  // significant digits.
  task automatic ref_fmt(input logic [31:0] v, input logic m, input logic lz,
                         output logic [31:0] d, output logic [7:0] b, output logic o);
    longint unsigned x;
    int nsig;
    d = v;
    o = 1'b0;
    if (m) begin
      x = longint'(v);
      for (int k = 0; k < 8; k++) begin
        d[4*k +: 4] = 4'(x % 10);
        x = x / 10;
      end
      o = (x != 0);
    end
    nsig = 1;
    for (int k = 1; k < 8; k++) begin
      if (d[4*k +: 4] != 4'd0) nsig = k + 1;
    end
    b = lz ? (8'hFF << nsig) : 8'h00;
  endtask

  // Present a request and let the next rising edge accept it, then scramble
  // the inputs so a design that fails to capture them is exposed.
  task automatic start_req(input logic [31:0] v, input logic m, input logic lz);
    value = v;
    mode  = m;
    lz_en = lz;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = $urandom;
    mode  = 1'($urandom_range(0, 1));
    lz_en = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag, input logic [31:0] v, input logic m,
                           input logic lz, input int poke);
    int n;
    bit seen;
    logic [31:0] ed;
    logic [7:0]  eb;
    logic        eo;
    n = 0;
    seen = 0;
    check({tag, "_busy_acc"}, 32'(busy), 32'd1);
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        seen = 1;
        start = 1'b0;
      end else if (n == poke) begin
        start = 1'b1;
        value = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(n), m ? 32'd33 : 32'd1);
    ref_fmt(v, m, lz, ed, eb, eo);
    check({tag, "_digits"}, digits, ed);
    check({tag, "_blank"}, 32'(blank), 32'(eb));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    last_digits = ed;
    last_blank  = eb;
    last_ovf    = eo;
  endtask

  task automatic hold_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_nodone"}, 32'(done), 32'd0);
    end
    check({tag, "_hold_digits"}, digits, last_digits);
    check({tag, "_hold_blank"}, 32'(blank), 32'(last_blank));
    check({tag, "_hold_ovf"}, 32'(overflow), 32'(last_ovf));
  endtask

  initial begin
    logic [31:0] rv;
    logic        rm;
    logic        rl;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    value = 32'h0;
    mode  = 1'b0;
    lz_en = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_digits", digits, 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    start_req(32'hDEADBEEF, 1'b0, 1'b1);
    wait_done("hex", 32'hDEADBEEF, 1'b0, 1'b1, 0);
    check("hex_digits_lit", digits, 32'hDEADBEEF);
    hold_check("hex", 3);

    @(negedge clk);
    start_req(32'd12345, 1'b1, 1'b1);
    wait_done("dec12345", 32'd12345, 1'b1, 1'b1, 0);
    check("dec12345_lit", digits, 32'h00012345);
    check("dec12345_blank_lit", 32'(blank), 32'hE0);

    @(negedge clk);
    start_req(32'hFFFFFFFF, 1'b1, 1'b1);
    wait_done("ovf", 32'hFFFFFFFF, 1'b1, 1'b1, 0);
    check("ovf_lit", digits, 32'h94967295);
    check("ovf_flag_lit", 32'(overflow), 32'd1);

    @(negedge clk);
    start_req(32'd0, 1'b1, 1'b1);
    wait_done("zero_lz", 32'd0, 1'b1, 1'b1, 0);
    check("zero_lz_blank_lit", 32'(blank), 32'hFE);
    @(negedge clk);
    start_req(32'd0, 1'b1, 1'b0);
    wait_done("zero_nolz", 32'd0, 1'b1, 1'b0, 0);

    // Reset partway through a decimal conversion.
    @(negedge clk);
    start_req(32'd123456789, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_digits", digits, 32'h0);
    check("midrst_blank", 32'(blank), 32'h0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("midrst_nodone", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_req(32'd99999999, 1'b1, 1'b0);
    wait_done("nines", 32'd99999999, 1'b1, 1'b0, 0);
    check("nines_lit", digits, 32'h99999999);

    // Start pulse while busy must be ignored.
    @(negedge clk);
    start_req(32'd4096, 1'b1, 1'b1);
    wait_done("poke", 32'd4096, 1'b1, 1'b1, 5);
    hold_check("poke", 40);

    // Back-to-back: new request presented during the done cycle.
    @(negedge clk);
    start_req(32'd31415926, 1'b1, 1'b1);
    wait_done("b2b_a", 32'd31415926, 1'b1, 1'b1, 0);
    start_req(32'd271828, 1'b1, 1'b1);
    wait_done("b2b_b", 32'd271828, 1'b1, 1'b1, 0);

    for (int i = 0; i < 20; i++) begin
      rv = $urandom >> $urandom_range(0, 31);
      rm = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 1));
      @(negedge clk);
      start_req(rv, rm, rl);
      wait_done($sformatf("rand%0d", i), rv, rm, rl, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/disp_num_fmt.md
DISP_NUM_FMT -- requirements
Module: disp_num_fmt

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  request to format value; sampled only in IDLE.
REQ-004 SHALL have port value  input  32  unsigned binary number to format; captured on the accepting edge.
REQ-005 SHALL have port mode  input  1  0 = hexadecimal, 1 = decimal (BCD); captured with value.
REQ-006 SHALL have port lz_en  input  1  1 = blank leading zero digits; captured with value.
REQ-007 SHALL have port busy  output  1  high while a request is in progress (state != IDLE).
REQ-008 SHALL have port done  output  1  one-cycle pulse; new results are valid in the same cycle.
REQ-009 SHALL have port digits  output  32  eight 4-bit digit codes for the per-display seven-segment decoders; digit k in bits [4k+3:4k], k=0 least significant, bit 4k+3 is the decoder MSB input.
REQ-010 SHALL have port blank  output  8  bit k = 1 means display k is to be turned off.
REQ-011 SHALL have port overflow  output  1  1 = decimal result needs more than 8 digits.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, FINISH; reset state IDLE.
REQ-013 SHALL, in IDLE with start=1 at edge E0, capture value/mode/lz_en, clear the internal BCD register, and go to FINISH if mode=0 or to SHIFT if mode=1.
REQ-014 SHALL, in SHIFT, perform one double-dabble step per edge: add 3 to every BCD nibble >= 5, then shift the working binary MSB into the BCD LSB; the BCD register is 40 bits (10 digits).
REQ-015 SHALL stay in SHIFT for exactly 32 edges (E1..E32), with the step counter reaching its final count on E32 and the state moving to FINISH.
REQ-016 SHALL, on the edge leaving FINISH, register digits/blank/overflow, drive done=1 for that one cycle, and return to IDLE.
REQ-017 SHALL give latency start-edge to done-high: 1 edge after FINISH in hex mode (done high after E1), 33 edges in decimal mode (done high after E33).
REQ-018 SHALL, in hex mode, set digits = captured value and overflow = 0.
REQ-019 SHALL, in decimal mode, set digits = lower 8 BCD digits and overflow = 1 iff either upper BCD digit (9 or 8) is non-zero.
REQ-020 SHALL, when lz_en=1, set blank[k]=1 for each k>=1 where digit k and all higher digits are zero; blank[0] is always 0; when lz_en=0, blank = 8'h00.
REQ-021 SHALL ignore start while busy=1; value/mode/lz_en changes during conversion SHALL NOT affect the result.
REQ-022 SHALL accept start in the done cycle (state already IDLE), allowing back-to-back requests.
REQ-023 SHALL hold digits/blank/overflow stable between done pulses.

Reset
REQ-024 SHALL, on rst_n=0 at any time, asynchronously force state IDLE, busy=0, done=0, digits=32'h0, blank=8'h00, overflow=0, and clear the BCD/step registers.
REQ-025 SHALL abandon an in-progress conversion on reset with no done pulse; operation resumes on the first clk edge after rst_n rises.

Verification
REQ-026 Hex: start, mode=0, lz_en=1, value=32'hDEADBEEF -> done after E1, digits=32'hDEADBEEF, blank=8'h00, overflow=0.
REQ-027 Decimal: mode=1, lz_en=1, value=12345 -> done exactly after E33, digits=32'h00012345, blank=8'hE0, overflow=0, busy high E0..E32.
REQ-028 Overflow: mode=1, value=32'hFFFFFFFF (4294967295) -> digits=32'h94967295, overflow=1, blank=8'h00.
REQ-029 Zero: mode=1, lz_en=1, value=0 -> digits=32'h0, blank=8'hFE; same with lz_en=0 -> blank=8'h00.
REQ-030 Reset mid-run: rst_n low at E10 of decimal conversion -> all outputs reset values immediately, no done; subsequent start with value=99999999 -> digits=32'h99999999, overflow=0.
REQ-031 Handshake: start pulsed at E5 while busy -> ignored (single done); start held in done cycle -> second request accepted, second done 33 edges later.
